// File: rtl/hera_uart_rx_pkg.sv
// rtl/hera_uart_rx_pkg.sv - shared FSM states, sampling constants and helpers for the HERA UART receiver
package hera_uart_rx_pkg;

  localparam int OVERSAMPLE = 16;

  // Bit value is voted from three samples around the middle of each bit cell
  localparam logic [3:0] MID_FIRST  = 4'd6;
  localparam logic [3:0] MID_SECOND = 4'd7;
  localparam logic [3:0] MID_LAST   = 4'd8;
  localparam logic [3:0] SAMPLE_MAX = 4'd15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } rx_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/hera_uart_rx_if.sv
// rtl/hera_uart_rx_if.sv - received-byte stream between the UART receiver and its consumer
interface hera_uart_rx_if;

  logic [7:0] data;
  logic       data_valid;
  logic       data_ready;

  modport master (
    output data,
    output data_valid,
    input  data_ready
  );

  modport slave (
    input  data,
    input  data_valid,
    output data_ready
  );

endinterface

// File: rtl/hera_sync_fifo.sv
// rtl/hera_sync_fifo.sv - single-clock FIFO; a pop frees room for a same-cycle push when full
module hera_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       head_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_ok;
  logic             pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_COUNT);
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/hera_uart_rx.sv
// rtl/hera_uart_rx.sv - 8N1 UART receiver with 16x oversampling, byte FIFO and cts flow control
module hera_uart_rx
  import hera_uart_rx_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int FIFO_DEPTH = 8,
  parameter int CTS_MARGIN = 2
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           rx_i,
  output logic           cts_o,
  output logic           frame_err_o,
  output logic           overrun_o,
  hera_uart_rx_if.master byte_if
);

  localparam int DIV = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
  localparam logic [CW-1:0] CTS_LIMIT = CW'(FIFO_DEPTH - CTS_MARGIN);

  logic            rx_meta_q, rx_sync_q;
  logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
  rx_state_e       state_q, state_d;
  logic [3:0]      s_q, s_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [1:0]      samp_q, samp_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;
  logic            cts_q, cts_d;
  logic            tick, mid, bit_val, push, pop, push_ok;
  logic [7:0]      fifo_head;
  logic            fifo_empty, fifo_full;
  logic [CW-1:0]   fifo_count, count_next;

  assign tick    = (tick_cnt_q == TICK_LAST);
  assign mid     = tick && (s_q == MID_LAST);
  assign bit_val = maj3(samp_q[1], samp_q[0], rx_sync_q);

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    samp_d      = samp_q;
    tick_cnt_d  = tick ? '0 : tick_cnt_q + 1'b1;
    push        = 1'b0;
    frame_err_d = 1'b0;
    if (tick && (s_q == MID_FIRST || s_q == MID_SECOND)) begin
      samp_d = {samp_q[0], rx_sync_q};
    end
    unique case (state_q)
      ST_IDLE: begin
        // Re-phase the tick counter to the start-bit edge
        if (!rx_sync_q) begin
          state_d    = ST_START;
          s_d        = '0;
          tick_cnt_d = '0;
        end
      end
      ST_START: begin
        if (tick) s_d = s_q + 1'b1;
        if (mid) begin
          state_d   = bit_val ? ST_IDLE : ST_DATA;
          bit_idx_d = '0;
        end
      end
      ST_DATA: begin
        if (tick) s_d = s_q + 1'b1;
        if (mid) begin
          shift_d   = {bit_val, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick) s_d = s_q + 1'b1;
        if (mid) begin
          if (bit_val) begin
            push    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_BREAK;
            s_d         = '0;
          end
        end
      end
      ST_BREAK: begin
        // s counts consecutive idle-high ticks here
        if (tick) begin
          if (!rx_sync_q)              s_d = '0;
          else if (s_q == SAMPLE_MAX)  state_d = ST_IDLE;
          else                         s_d = s_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign pop       = byte_if.data_valid & byte_if.data_ready;
  assign push_ok   = push & (~fifo_full | pop);
  assign overrun_d = push & fifo_full & ~pop;

  always_comb begin
    count_next = fifo_count;
    if (push_ok && !pop)      count_next = fifo_count + 1'b1;
    else if (pop && !push_ok) count_next = fifo_count - 1'b1;
  end

  assign cts_d = (count_next < CTS_LIMIT);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      tick_cnt_q  <= '0;
      state_q     <= ST_IDLE;
      s_q         <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      samp_q      <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      cts_q       <= 1'b1;
    end else begin
      rx_meta_q   <= rx_i;
      rx_sync_q   <= rx_meta_q;
      tick_cnt_q  <= tick_cnt_d;
      state_q     <= state_d;
      s_q         <= s_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      samp_q      <= samp_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      cts_q       <= cts_d;
    end
  end

  hera_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push),
    .push_data_i (shift_q),
    .pop_i       (pop),
    .head_o      (fifo_head),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full),
    .count_o     (fifo_count)
  );

  assign byte_if.data       = fifo_head;
  assign byte_if.data_valid = ~fifo_empty;
  assign cts_o              = cts_q;
  assign frame_err_o        = frame_err_q;
  assign overrun_o          = overrun_q;

endmodule

// File: tb/tb_hera_uart_rx.sv
// tb/tb_hera_uart_rx.sv - self-checking bench for hera_uart_rx at 32 clocks per bit
module tb_hera_uart_rx;

  localparam int CLK_HZ   = 3_200_000;
  localparam int BAUD     = 100_000;
  localparam int BIT_CLKS = 32;
  localparam int DEPTH    = 8;
  localparam int MARGIN   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic cts, frame_err, overrun;

  hera_uart_rx_if bus ();

  hera_uart_rx #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (DEPTH),
    .CTS_MARGIN (MARGIN)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .rx_i        (rx),
    .cts_o       (cts),
    .frame_err_o (frame_err),
    .overrun_o   (overrun),
    .byte_if     (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int fe_rise = 0, fe_hi = 0, ov_rise = 0, ov_hi = 0, both_hi = 0, v_hi = 0;
  int t_rise = -1;
  logic fe_prev = 1'b0, ov_prev = 1'b0, v_prev = 1'b0;
  logic [7:0] got_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Observe outputs mid-cycle: handshakes seen here complete on the next rising edge
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.data_valid && bus.data_ready) got_q.push_back(bus.data);
      if (bus.data_valid && !v_prev) t_rise <= cyc;
      if (bus.data_valid) v_hi <= v_hi + 1;
      if (frame_err) fe_hi <= fe_hi + 1;
      if (frame_err && !fe_prev) fe_rise <= fe_rise + 1;
      if (overrun) ov_hi <= ov_hi + 1;
      if (overrun && !ov_prev) ov_rise <= ov_rise + 1;
      if (frame_err && overrun) both_hi <= both_hi + 1;
    end
    fe_prev <= frame_err;
    ov_prev <= overrun;
    v_prev  <= bus.data_valid;
  end

  int tests_run = 0;
  int tests_failed = 0;
  logic [7:0] exp_q[$];
  int t_fall;
  int lat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One 8N1 frame, LSB first; caller sits 1 ns after a rising edge
  task automatic send_byte(input logic [7:0] b, input logic stop);
    logic [9:0] frame;
    frame  = {stop, b, 1'b0};
    t_fall = cyc;
    for (int i = 0; i < 10; i++) begin
      rx = frame[i];
      repeat (BIT_CLKS) @(posedge clk);
      #1;
    end
  endtask

  task automatic check_stream(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check({tag, "_byte"}, 32'(got_q[i]), 32'(exp_q[i]));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int v0, f0, fh0, o0, oh0, r0, occ;
    logic [7:0] b;
    logic done;

    bus.data_ready = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("rst_cts", cts, 1);
    check("rst_valid", bus.data_valid, 0);
    check("rst_data", bus.data, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overrun", overrun, 0);
    rst = 1'b0;
    idle(10);

    // 1: single byte with consumer ready
    bus.data_ready = 1'b1;
    v0 = v_hi; f0 = fe_hi; o0 = ov_hi; r0 = t_rise;
    send_byte(8'hA5, 1'b1);
    idle(8);
    exp_q.push_back(8'hA5);
    lat = t_rise - t_fall;
    check("t1_valid_rose", 32'(t_rise != r0), 1);
    check("t1_valid_in_stop_bit", 32'(lat >= 9 * BIT_CLKS + 8 && lat <= 10 * BIT_CLKS - 4), 1);
    check("t1_valid_one_clk", v_hi - v0, 1);
    check("t1_no_frame_err", fe_hi - f0, 0);
    check("t1_no_overrun", ov_hi - o0, 0);
    check_stream("t1");
    if (lat < 2 || lat > 10 * BIT_CLKS) lat = 9 * BIT_CLKS + BIT_CLKS / 2;

    // 2: start-bit glitch of 4 ticks
    v0 = v_hi; f0 = fe_hi; o0 = ov_hi;
    rx = 1'b0;
    idle(8);
    rx = 1'b1;
    idle(400);
    check("t2_no_valid", v_hi - v0, 0);
    check("t2_no_frame_err", fe_hi - f0, 0);
    check("t2_no_overrun", ov_hi - o0, 0);
    check_stream("t2");

    // 3: framing error, break, then recovery
    f0 = fe_rise; fh0 = fe_hi;
    send_byte(8'h3C, 1'b0);
    idle(2 * BIT_CLKS);
    rx = 1'b1;
    idle(2 * BIT_CLKS);
    check("t3_frame_err_pulses", fe_rise - f0, 1);
    check("t3_frame_err_width", fe_hi - fh0, 1);
    check_stream("t3_dropped");
    send_byte(8'h7E, 1'b1);
    idle(16);
    exp_q.push_back(8'h7E);
    check_stream("t3_after_break");

    // 4: back-to-back fill past capacity with consumer stalled
    bus.data_ready = 1'b0;
    o0 = ov_rise; oh0 = ov_hi;
    for (int i = 1; i <= 9; i++) begin
      send_byte(8'(i), 1'b1);
      occ = (i > DEPTH) ? DEPTH : i;
      if (i <= DEPTH) exp_q.push_back(8'(i));
      check("t4_cts", cts, 32'((DEPTH - occ) > MARGIN));
    end
    idle(2);
    check("t4_overrun_pulses", ov_rise - o0, 1);
    check("t4_overrun_width", ov_hi - oh0, 1);
    check("t4_no_collision", both_hi, 0);
    bus.data_ready = 1'b1;
    idle(20);
    check_stream("t4");
    check("t4_cts_restored", cts, 1);

    // 5: pop coincides with the push into a full FIFO
    bus.data_ready = 1'b0;
    o0 = ov_rise;
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'($urandom);
      send_byte(b, 1'b1);
      exp_q.push_back(b);
    end
    b = 8'($urandom);
    fork
      send_byte(b, 1'b1);
      begin
        repeat (lat - 1) @(posedge clk);
        #1 bus.data_ready = 1'b1;
        @(posedge clk);
        #1 bus.data_ready = 1'b0;
      end
    join
    exp_q.push_back(b);
    idle(2);
    check("t5_no_overrun", ov_rise - o0, 0);
    check("t5_cts_full", cts, 0);
    check("t5_valid", bus.data_valid, 1);
    bus.data_ready = 1'b1;
    idle(20);
    check_stream("t5");

    // 6: reset in the middle of a frame with bytes queued
    bus.data_ready = 1'b0;
    for (int i = 0; i < 6; i++) send_byte(8'($urandom), 1'b1);
    check("t6_cts_before_rst", cts, 0);
    fork
      send_byte(8'hFF, 1'b1);
      begin
        repeat (4 * BIT_CLKS + 12) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("t6_rst_cts", cts, 1);
        check("t6_rst_valid", bus.data_valid, 0);
        check("t6_rst_data", bus.data, 0);
        check("t6_rst_frame_err", frame_err, 0);
        check("t6_rst_overrun", overrun, 0);
      end
    join
    bus.data_ready = 1'b1;
    idle(40);
    send_byte(8'h5A, 1'b1);
    idle(16);
    exp_q.push_back(8'h5A);
    check_stream("t6");

    // 7: random bytes, random gaps, randomly stalling consumer
    f0 = fe_rise; o0 = ov_rise;
    done = 1'b0;
    fork
      begin
        for (int k = 0; k < 10; k++) begin
          b = 8'($urandom);
          send_byte(b, 1'b1);
          exp_q.push_back(b);
          idle($urandom_range(0, 40));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 bus.data_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    bus.data_ready = 1'b1;
    idle(20);
    check_stream("t7");
    check("t7_no_frame_err", fe_rise - f0, 0);
    check("t7_no_overrun", ov_rise - o0, 0);
    check("t7_cts", cts, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
